stage_multiwave_generator: RTL and testbench
============================================

Name: stage_multiwave_generator

Overview:
- Parametrised next-generation waveform stage of the operator pipeline; sits between the phase accumulator stage and the envelope/attenuation stage.
- Per sample, each operator selects one of four waveforms: sine, triangle, sawtooth or square.
- The quarter-wave sine table is a RAM loaded at boot through a write port.
- A load state machine mutes the output until the table has been loaded.

Parameters:
- PHASE_WIDTH, 17, signed phase input width; MSB (sign) ignored.
- TABLE_ADDR_WIDTH, 14, quarter-wave table address bits; the table holds 2^TABLE_ADDR_WIDTH entries. Must satisfy TABLE_ADDR_WIDTH <= PHASE_WIDTH-3.
- SAMPLE_WIDTH, 16, signed output width. Each table entry is SAMPLE_WIDTH-1 bits unsigned. Must satisfy TABLE_ADDR_WIDTH <= SAMPLE_WIDTH-1.

Ports:
- i_Clock  in  1  clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_VoiceOperator  in  VoiceOperatorID_t  operator ID; passed through.
- o_VoiceOperator  out  VoiceOperatorID_t  delayed operator ID.
- i_AlgorithmWord  in  AlgorithmWord_t  passed through.
- o_AlgorithmWord  out  AlgorithmWord_t  delayed.
- i_NoteOn  in  1  passed through.
- o_NoteOn  out  1  delayed.
- i_WaveSelect  in  2  waveform select: 0 sine, 1 triangle, 2 sawtooth, 3 square.
- i_Phase  in  PHASE_WIDTH  signed phase.
- o_Waveform  out  SAMPLE_WIDTH  signed sample.
- i_TableWriteEnable  in  1  table write strobe.
- i_TableWriteAddress  in  TABLE_ADDR_WIDTH  table write address.
- i_TableWriteData  in  SAMPLE_WIDTH-1  table write data.
- i_TableReload  in  1  single-cycle pulse; returns the block to LOADING.
- o_TableReady  out  1  high when the table is valid.

Behaviour:
- Definitions:
  - P = i_Phase[PHASE_WIDTH-2:0].
  - NegOut = P[msb].
  - NegPhase = P[msb-1].
  - Index = the next TABLE_ADDR_WIDTH bits down; lower bits are truncated.
  - FoldIdx = NegPhase ? ~Index : Index.
- Latency is exactly 3 cycles for o_Waveform and all sidebands, fully pipelined, one sample per clock, no stalls.
  - Clock 1 registers FoldIdx, NegOut, select, top SAMPLE_WIDTH bits of P, and sidebands.
  - Clock 2 performs the table read.
  - Clock 3 forms the output.
- Sine: mag = {0, table[FoldIdx]}; out = NegOut ? ~mag : mag. Negation is ones' complement.
- Triangle: mag = {0, FoldIdx << (SAMPLE_WIDTH-1-TABLE_ADDR_WIDTH)}; same negation rule as sine.
- Sawtooth: out = top SAMPLE_WIDTH bits of P with the MSB inverted (linear ramp from -2^(SW-1) to 2^(SW-1)-1).
- Square: out = NegOut ? {1, 0...} : {0, 1...}.
- Table RAM: 1 write port and 1 read port, read data registered. The RAM is not cleared by reset.
- Load FSM: two states, LOADING and READY.
  - Reset forces LOADING.
  - In LOADING: writes are accepted. A write to address 2^TABLE_ADDR_WIDTH-1 moves to READY on the next cycle. Writes in any order are allowed; only the last-address write triggers the transition.
  - In READY: i_TableWriteEnable is ignored; i_TableReload moves to LOADING on the next cycle.
  - Reload and write in the same cycle while READY: the write is ignored and the state goes to LOADING.
  - Reload while already LOADING: no effect.
  - o_TableReady = (state == READY), registered.
- Muting: o_Waveform is forced to 0 on any cycle whose stage-3 register update sees state != READY. This applies to all waveforms, including table-free ones. Sidebands propagate regardless.
- Reset values: o_Waveform 0, o_NoteOn 0, o_VoiceOperator 0, o_AlgorithmWord 0, o_TableReady 0, all pipeline registers 0.
- Reset mid-stream: outputs read 0 from the next cycle; the pipeline refills over 3 cycles; the table must be reloaded (or its last address rewritten) to return to READY.

Test Plan:
1. Hold reset 2 cycles, then apply a sine phase with no table load -> o_TableReady=0 and o_Waveform=0 for all cycles; o_NoteOn still follows i_NoteOn delayed by 3 cycles.
2. Load table[i]=i for all 16384 entries, last write at 0x3FFF -> o_TableReady rises the following cycle. Then sine at phase 0x00010 -> 0x0010 after 3 cycles. Sine at phase 0x0C010 -> 0xC010. Sine at phase 0x04000 -> table[0x3FFF]=0x3FFF.
3. With table loaded, triangle at phase 0x0C010 -> 0x8021 (FoldIdx 0x3FEF, mag 0x7FDE, inverted). Triangle at phase 0x00000 -> 0x0000.
4. Sawtooth at phase 0x00000 -> 0x8000. Sawtooth at phase 0x1FFFF -> 0x7FFF (sign ignored). Square at phase 0x08000 -> 0x8000. Square at phase 0x07FFF -> 0x7FFF.
5. Stream back-to-back samples with a different i_WaveSelect each cycle -> each output matches its own selection exactly 3 cycles later; no cross-contamination between samples.
6. Pulse i_TableReload in READY together with a write to 0x0005 -> table[5] unchanged, o_TableReady falls next cycle, o_Waveform 0 for in-flight samples. Then rewrite 0x3FFF only -> READY restored and the prior table contents are still used.

Source files
------------

// File: rtl/stage_multiwave_generator_if.sv
// rtl/stage_multiwave_generator_if.sv - sine table load bus for the multiwave generator stage
//
// Purpose: groups the quarter-wave table write port, the reload pulse and the
// ready flag so the boot loader and the waveform stage share one connection.
// Signals:
//   i_TableWriteEnable   table write strobe          (master -> slave)
//   i_TableWriteAddress  table write address         (master -> slave)
//   i_TableWriteData     unsigned table entry        (master -> slave)
//   i_TableReload        one-cycle reload request    (master -> slave)
//   o_TableReady         table valid, registered     (slave -> master)
interface stage_multiwave_generator_if #(
    parameter int TABLE_ADDR_WIDTH = 14,
    parameter int SAMPLE_WIDTH     = 16
);
    logic                          i_TableWriteEnable;
    logic [TABLE_ADDR_WIDTH-1:0]   i_TableWriteAddress;
    logic [SAMPLE_WIDTH-2:0]       i_TableWriteData;
    logic                          i_TableReload;
    logic                          o_TableReady;

    modport master (
        output i_TableWriteEnable,
        output i_TableWriteAddress,
        output i_TableWriteData,
        output i_TableReload,
        input  o_TableReady
    );

    modport slave (
        input  i_TableWriteEnable,
        input  i_TableWriteAddress,
        input  i_TableWriteData,
        input  i_TableReload,
        output o_TableReady
    );
endinterface

// File: rtl/stage_multiwave_generator.sv
// rtl/stage_multiwave_generator.sv - per-operator sine/triangle/sawtooth/square waveform stage
//
// Purpose: converts an operator phase into a signed sample of the selected
// waveform. Three register stages (capture/fold, table read, output form),
// one sample per clock. Output is muted until the quarter-wave sine table
// has been loaded through the table bus.
// Ports:
//   i_Clock, i_Reset         clock, synchronous active-high reset
//   i_VoiceOperator/o_...    operator ID sideband, delayed 3 cycles
//   i_AlgorithmWord/o_...    algorithm sideband, delayed 3 cycles
//   i_NoteOn/o_NoteOn        note-on sideband, delayed 3 cycles
//   i_WaveSelect             0 sine, 1 triangle, 2 sawtooth, 3 square
//   i_Phase                  signed phase, sign bit ignored
//   o_Waveform               signed sample, 0 while the table is not ready
//   tableBus                 table write port, reload pulse, ready flag
module stage_multiwave_generator #(
    parameter int  PHASE_WIDTH      = 17,
    parameter int  TABLE_ADDR_WIDTH = 14,
    parameter int  SAMPLE_WIDTH     = 16,
    parameter type VoiceOperatorID_t = logic [4:0],
    parameter type AlgorithmWord_t   = logic [2:0]
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  VoiceOperatorID_t        i_VoiceOperator,
    output VoiceOperatorID_t        o_VoiceOperator,
    input  AlgorithmWord_t          i_AlgorithmWord,
    output AlgorithmWord_t          o_AlgorithmWord,
    input  logic                    i_NoteOn,
    output logic                    o_NoteOn,
    input  logic [1:0]              i_WaveSelect,
    input  logic [PHASE_WIDTH-1:0]  i_Phase,
    output logic [SAMPLE_WIDTH-1:0] o_Waveform,
    stage_multiwave_generator_if.slave tableBus
);
    localparam int PW  = PHASE_WIDTH;
    localparam int TAW = TABLE_ADDR_WIDTH;
    localparam int SW  = SAMPLE_WIDTH;
    // Triangle magnitude is the folded index scaled up to fill SW-1 bits.
    localparam int TRI_SHIFT = SW - 1 - TAW;
    localparam int TABLE_DEPTH = 2 ** TAW;
    localparam logic [TAW-1:0] LAST_ADDRESS = '1;

    localparam logic [1:0] WAVE_SINE     = 2'd0;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd1;
    localparam logic [1:0] WAVE_SAWTOOTH = 2'd2;

    generate
        if (TAW > PW - 3) begin : gBadPhase
            $error("TABLE_ADDR_WIDTH must not exceed PHASE_WIDTH-3");
        end
        if (TAW > SW - 1) begin : gBadSample
            $error("TABLE_ADDR_WIDTH must not exceed SAMPLE_WIDTH-1");
        end
    endgenerate

    typedef enum logic {
        LOADING = 1'b0,
        READY   = 1'b1
    } LoadState_t;

    LoadState_t loadState;

    // Phase decomposition: the top unsigned bit picks the half wave, the next
    // picks the rising/falling quarter, and the quarter index is mirrored on
    // the falling quarter so one quarter-wave table serves the whole cycle.
    logic           negOutIn;
    logic           negPhaseIn;
    logic [TAW-1:0] indexIn;
    logic [TAW-1:0] foldIdxIn;
    logic [SW-1:0]  rampIn;

    assign negOutIn   = i_Phase[PW-2];
    assign negPhaseIn = i_Phase[PW-3];
    assign indexIn    = i_Phase[PW-4 -: TAW];
    assign foldIdxIn  = negPhaseIn ? ~indexIn : indexIn;
    assign rampIn     = i_Phase[PW-2 -: SW];

    // Stage 1: captured phase fields and sidebands.
    logic [TAW-1:0]   s1FoldIdx;
    logic             s1NegOut;
    logic [1:0]       s1Select;
    logic [SW-1:0]    s1Ramp;
    logic             s1NoteOn;
    VoiceOperatorID_t s1VoiceOperator;
    AlgorithmWord_t   s1AlgorithmWord;

    // Stage 2: table read data plus the fields forwarded alongside it.
    logic [SW-2:0]    tableReadData;
    logic [TAW-1:0]   s2FoldIdx;
    logic             s2NegOut;
    logic [1:0]       s2Select;
    logic [SW-1:0]    s2Ramp;
    logic             s2NoteOn;
    VoiceOperatorID_t s2VoiceOperator;
    AlgorithmWord_t   s2AlgorithmWord;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s1FoldIdx       <= '0;
            s1NegOut        <= 1'b0;
            s1Select        <= '0;
            s1Ramp          <= '0;
            s1NoteOn        <= 1'b0;
            s1VoiceOperator <= '0;
            s1AlgorithmWord <= '0;
            s2FoldIdx       <= '0;
            s2NegOut        <= 1'b0;
            s2Select        <= '0;
            s2Ramp          <= '0;
            s2NoteOn        <= 1'b0;
            s2VoiceOperator <= '0;
            s2AlgorithmWord <= '0;
        end else begin
            s1FoldIdx       <= foldIdxIn;
            s1NegOut        <= negOutIn;
            s1Select        <= i_WaveSelect;
            s1Ramp          <= rampIn;
            s1NoteOn        <= i_NoteOn;
            s1VoiceOperator <= i_VoiceOperator;
            s1AlgorithmWord <= i_AlgorithmWord;
            s2FoldIdx       <= s1FoldIdx;
            s2NegOut        <= s1NegOut;
            s2Select        <= s1Select;
            s2Ramp          <= s1Ramp;
            s2NoteOn        <= s1NoteOn;
            s2VoiceOperator <= s1VoiceOperator;
            s2AlgorithmWord <= s1AlgorithmWord;
        end
    end

    // Quarter-wave table. Contents survive reset; only the read register clears.
    logic [SW-2:0] tableMem [TABLE_DEPTH];
    logic          tableWriteAccept;

    assign tableWriteAccept = tableBus.i_TableWriteEnable && (loadState == LOADING) && !i_Reset;

    always_ff @(posedge i_Clock) begin
        if (tableWriteAccept) begin
            tableMem[tableBus.i_TableWriteAddress] <= tableBus.i_TableWriteData;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tableReadData <= '0;
        end else begin
            tableReadData <= tableMem[s1FoldIdx];
        end
    end

    // Load FSM: leaves LOADING only on a write to the last table address,
    // leaves READY only on a reload pulse (a simultaneous write is dropped).
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            loadState             <= LOADING;
            tableBus.o_TableReady <= 1'b0;
        end else begin
            case (loadState)
                LOADING: begin
                    if (tableBus.i_TableWriteEnable && (tableBus.i_TableWriteAddress == LAST_ADDRESS)) begin
                        loadState             <= READY;
                        tableBus.o_TableReady <= 1'b1;
                    end
                end
                READY: begin
                    if (tableBus.i_TableReload) begin
                        loadState             <= LOADING;
                        tableBus.o_TableReady <= 1'b0;
                    end
                end
                default: begin
                    loadState             <= LOADING;
                    tableBus.o_TableReady <= 1'b0;
                end
            endcase
        end
    end

    // Stage 3 output forming. Negation of the table-based waves is ones'
    // complement so the two half waves stay exactly symmetric around -0.5.
    logic [SW-1:0] sineMag;
    logic [SW-1:0] triMag;
    logic [SW-1:0] nextWaveform;

    always_comb begin
        sineMag      = {1'b0, tableReadData};
        triMag       = SW'(s2FoldIdx) << TRI_SHIFT;
        nextWaveform = '0;
        case (s2Select)
            WAVE_SINE:     nextWaveform = s2NegOut ? ~sineMag : sineMag;
            WAVE_TRIANGLE: nextWaveform = s2NegOut ? ~triMag : triMag;
            WAVE_SAWTOOTH: nextWaveform = {~s2Ramp[SW-1], s2Ramp[SW-2:0]};
            default:       nextWaveform = s2NegOut ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Waveform      <= '0;
            o_NoteOn        <= 1'b0;
            o_VoiceOperator <= '0;
            o_AlgorithmWord <= '0;
        end else begin
            o_Waveform      <= (loadState == READY) ? nextWaveform : '0;
            o_NoteOn        <= s2NoteOn;
            o_VoiceOperator <= s2VoiceOperator;
            o_AlgorithmWord <= s2AlgorithmWord;
        end
    end
endmodule

// File: tb/tb_stage_multiwave_generator.sv
// tb/tb_stage_multiwave_generator.sv - randomized self-checking bench for stage_multiwave_generator
module tb_stage_multiwave_generator;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  voiceOperatorIn;
    logic [4:0]  voiceOperatorOut;
    logic [2:0]  algorithmWordIn;
    logic [2:0]  algorithmWordOut;
    logic        noteOnIn;
    logic        noteOnOut;
    logic [1:0]  waveSelect;
    logic [16:0] phase;
    logic [15:0] waveform;

    int assertCount = 0;
    int failCount   = 0;
    int edgeCount   = 0;

    stage_multiwave_generator_if tableBus ();

    stage_multiwave_generator dut (
        .i_Clock         (clock),
        .i_Reset         (reset),
        .i_VoiceOperator (voiceOperatorIn),
        .o_VoiceOperator (voiceOperatorOut),
        .i_AlgorithmWord (algorithmWordIn),
        .o_AlgorithmWord (algorithmWordOut),
        .i_NoteOn        (noteOnIn),
        .o_NoteOn        (noteOnOut),
        .i_WaveSelect    (waveSelect),
        .i_Phase         (phase),
        .o_Waveform      (waveform),
        .tableBus        (tableBus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [16:0] phase;
        logic [1:0]  sel;
        logic        noteOn;
        logic [4:0]  op;
        logic [2:0]  alg;
        logic [15:0] val;
    } Sample_t;

    Sample_t     slots [4];
    logic [14:0] modelTable [16384];
    bit          modelReady = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, actual, expected, edgeCount);
        end
    endtask

    // Reference waveform computed from the phase with plain integer arithmetic.
    function automatic logic [15:0] waveOf(input logic [1:0] sel, input logic [16:0] ph);
        int p, q, fold, mag;
        bit negOut, negPhase;
        p        = int'(ph) % 65536;
        negOut   = (p >= 32768);
        q        = p % 32768;
        negPhase = (q >= 16384);
        fold     = negPhase ? 16383 - (q % 16384) : q % 16384;
        case (sel)
            2'd0:    mag = int'(modelTable[fold]);
            2'd1:    mag = fold * 2;
            2'd2:    return 16'((p + 32768) % 65536);
            default: return negOut ? 16'h8000 : 16'h7FFF;
        endcase
        return negOut ? 16'(65535 - mag) : 16'(mag);
    endfunction

    // One clock: the sample presented now emerges three edges later, the table
    // is read on the middle edge, and muting follows the table state just
    // before the output edge.
    task automatic runCycle();
        Sample_t     cur;
        logic [15:0] expWave;
        logic        expNote;
        logic [4:0]  expOp;
        logic [2:0]  expAlg;
        int s0, s1, s2;
        s0 = edgeCount % 4;
        s1 = (edgeCount + 3) % 4;
        s2 = (edgeCount + 2) % 4;
        cur.phase  = phase;
        cur.sel    = waveSelect;
        cur.noteOn = noteOnIn;
        cur.op     = voiceOperatorIn;
        cur.alg    = algorithmWordIn;
        cur.val    = '0;
        slots[s0]  = cur;
        slots[s1].val = waveOf(slots[s1].sel, slots[s1].phase);
        if (reset) begin
            slots[s0] = '0;
            slots[s1] = '0;
            slots[s2] = '0;
        end
        expWave = modelReady ? slots[s2].val : 16'h0000;
        expNote = slots[s2].noteOn;
        expOp   = slots[s2].op;
        expAlg  = slots[s2].alg;
        if (reset) begin
            modelReady = 1'b0;
        end else if (!modelReady) begin
            if (tableBus.i_TableWriteEnable) begin
                modelTable[int'(tableBus.i_TableWriteAddress)] = tableBus.i_TableWriteData;
                if (tableBus.i_TableWriteAddress == 14'h3FFF) modelReady = 1'b1;
            end
        end else if (tableBus.i_TableReload) begin
            modelReady = 1'b0;
        end
        @(posedge clock);
        #1;
        checkValue("waveform", 32'(waveform), 32'(expWave));
        checkValue("note_on", 32'(noteOnOut), 32'(expNote));
        checkValue("voice_operator", 32'(voiceOperatorOut), 32'(expOp));
        checkValue("algorithm_word", 32'(algorithmWordOut), 32'(expAlg));
        checkValue("table_ready", 32'(tableBus.o_TableReady), 32'(modelReady));
        edgeCount++;
    endtask

    task automatic randomInputs();
        waveSelect      = 2'($urandom_range(0, 3));
        phase           = 17'($urandom);
        noteOnIn        = 1'($urandom_range(0, 1));
        voiceOperatorIn = 5'($urandom);
        algorithmWordIn = 3'($urandom);
        tableBus.i_TableWriteEnable  = 1'b0;
        tableBus.i_TableWriteAddress = 14'($urandom);
        tableBus.i_TableWriteData    = 15'($urandom);
        tableBus.i_TableReload       = 1'b0;
    endtask

    task automatic randomStream(input int cycles, input bit noisyWrites);
        for (int i = 0; i < cycles; i++) begin
            randomInputs();
            if (noisyWrites) tableBus.i_TableWriteEnable = 1'($urandom_range(0, 1));
            runCycle();
        end
    endtask

    task automatic directed(input string tag, input logic [1:0] sel, input logic [16:0] ph, input logic [15:0] expected);
        randomInputs();
        waveSelect = sel;
        phase      = ph;
        runCycle();
        randomInputs();
        runCycle();
        randomInputs();
        runCycle();
        checkValue(tag, 32'(waveform), 32'(expected));
    endtask

    task automatic writeLast(input logic [14:0] data);
        randomInputs();
        tableBus.i_TableWriteEnable  = 1'b1;
        tableBus.i_TableWriteAddress = 14'h3FFF;
        tableBus.i_TableWriteData    = data;
        runCycle();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) slots[i] = '0;
        randomInputs();
        reset = 1'b1;
        runCycle();
        runCycle();
        reset = 1'b0;
        checkValue("reset_ready", 32'(tableBus.o_TableReady), 32'd0);
        checkValue("reset_wave", 32'(waveform), 32'd0);

        // Unloaded table: sidebands flow, output muted.
        randomStream(12, 1'b0);

        // Full load with table[i] = i, samples muted while loading.
        for (int i = 0; i < 16384; i++) begin
            randomInputs();
            tableBus.i_TableWriteEnable  = 1'b1;
            tableBus.i_TableWriteAddress = 14'(i);
            tableBus.i_TableWriteData    = 15'(i);
            if (i == 16383) checkValue("ready_before_last", 32'(tableBus.o_TableReady), 32'd0);
            runCycle();
        end
        checkValue("ready_after_load", 32'(tableBus.o_TableReady), 32'd1);

        directed("sine_0x00010", 2'd0, 17'h00010, 16'h0010);
        directed("sine_0x0C010", 2'd0, 17'h0C010, 16'hC010);
        directed("sine_0x04000", 2'd0, 17'h04000, 16'h3FFF);
        directed("tri_0x0C010",  2'd1, 17'h0C010, 16'h8021);
        directed("tri_0x00000",  2'd1, 17'h00000, 16'h0000);
        directed("saw_0x00000",  2'd2, 17'h00000, 16'h8000);
        directed("saw_0x1FFFF",  2'd2, 17'h1FFFF, 16'h7FFF);
        directed("sq_0x08000",   2'd3, 17'h08000, 16'h8000);
        directed("sq_0x07FFF",   2'd3, 17'h07FFF, 16'h7FFF);

        // Back-to-back mixed selections; writes in READY must be ignored.
        randomStream(300, 1'b1);

        // Reload together with a write to address 5: write dropped.
        randomInputs();
        tableBus.i_TableReload       = 1'b1;
        tableBus.i_TableWriteEnable  = 1'b1;
        tableBus.i_TableWriteAddress = 14'h0005;
        tableBus.i_TableWriteData    = 15'h1234;
        runCycle();
        checkValue("ready_fall", 32'(tableBus.o_TableReady), 32'd0);
        randomStream(6, 1'b0);
        writeLast(15'h3FFF);
        checkValue("ready_restored", 32'(tableBus.o_TableReady), 32'd1);
        directed("sine_keeps_t5", 2'd0, 17'h00005, 16'h0005);
        randomStream(100, 1'b0);

        // Reload, scattered random writes, then the last address.
        randomInputs();
        tableBus.i_TableReload = 1'b1;
        runCycle();
        for (int i = 0; i < 200; i++) begin
            randomInputs();
            tableBus.i_TableWriteEnable  = 1'($urandom_range(0, 1));
            tableBus.i_TableWriteAddress = 14'($urandom_range(0, 16382));
            if (i % 3 == 0) tableBus.i_TableReload = 1'b1;
            runCycle();
        end
        writeLast(15'($urandom));
        randomStream(300, 1'b1);

        // Reset mid-stream, then restore READY by rewriting the last address.
        randomInputs();
        reset = 1'b1;
        runCycle();
        reset = 1'b0;
        checkValue("midreset_wave", 32'(waveform), 32'd0);
        checkValue("midreset_note", 32'(noteOnOut), 32'd0);
        randomStream(8, 1'b0);
        writeLast(15'($urandom));
        randomStream(100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
